vga_pattern_scheduler: RTL and testbench
========================================

Name: vga_pattern_scheduler

Overview:
- Sequences the 3-bit pattern select that drives the colour-bar generator's `switch` input.
- Pattern changes are only ever applied at a frame boundary, so no frame shows mixed patterns.
- Auto mode: the block cycles through patterns after a programmable number of frames.
- Manual mode: step and load requests are queued and applied at the next boundary.
- Sits between the board switches/buttons and the VGA timing/colour block.
- Consumes that block's `hcount1`/`vcount1` outputs.

Parameters:
- NUM_PATTERNS, 5, number of valid patterns (0..NUM_PATTERNS-1); legal range 2..8.
- DWELL_FRAMES, 60, frames each pattern is shown in auto mode; legal range 1..65535.
- H_W, 11, hcount width.
- V_W, 10, vcount width.

Ports:
- clk  in  1  system clock; hcount/vcount are sampled on this clock.
- rst  in  1  asynchronous, active-high reset.
- hcount  in  H_W  current horizontal pixel count from timing generator.
- vcount  in  V_W  current line count from timing generator.
- auto_en  in  1  level; 1 = auto mode, 0 = manual mode.
- step  in  1  synchronous level; each rising edge requests next pattern (manual only).
- load  in  1  synchronous level; each rising edge requests manual_sel (manual only).
- manual_sel  in  3  pattern requested by load.
- pattern_sel  out  3  registered pattern select to colour generator.
- frame_start  out  1  one-clk pulse per frame boundary.
- pattern_changed  out  1  one-clk pulse when pattern_sel updates.
- pending  out  1  a manual request is queued and awaiting a boundary.
- auto_mode  out  1  registered copy of the current mode.
- frame_cnt  out  16  free-running frame counter, wraps at 65535 to 0.

Behaviour:
- Reset (asynchronous, any time including mid-frame) sets:
  - pattern_sel=0, frame_start=0, pattern_changed=0, pending=0, auto_mode=0, frame_cnt=0;
  - dwell counter=0, pending_sel=0, edge-detect registers=0;
  - FSM to WAIT_SYNC.
- Boundary detect:
  - at_origin = (hcount==0 && vcount==0); register it each clk.
  - frame_start=1 on the clk after at_origin goes 0->1.
  - Exactly one pulse per frame, although the timing generator holds (0,0) for two clks.
- frame_cnt increments on every frame_start.
- FSM states: WAIT_SYNC, RUN_MANUAL, RUN_AUTO.
- WAIT_SYNC:
  - pattern_sel held at 0; step and load ignored.
  - On first frame_start, go to RUN_AUTO if auto_en=1, else RUN_MANUAL.
  - Dwell counter cleared.
- Mode change:
  - auto_en is sampled each clk; a change moves RUN_MANUAL<->RUN_AUTO on the next clk.
  - The change clears the dwell counter and the pending flag.
  - pattern_sel is unchanged.
  - auto_mode reflects the state (1 in RUN_AUTO).
- RUN_AUTO:
  - Each frame_start increments the dwell counter.
  - When a frame_start arrives with counter==DWELL_FRAMES-1, the counter clears to 0 and pattern_sel advances (NUM_PATTERNS-1 wraps to 0).
  - step and load are ignored.
- RUN_MANUAL requests are edge-detected with internal registers:
  - step edge: pending_sel = (pending ? pending_sel : pattern_sel) + 1, with wrap; pending=1.
  - load edge: pending_sel = manual_sel, or 0 if manual_sel >= NUM_PATTERNS; pending=1.
  - step and load edges in the same clk: load wins.
  - Multiple requests within one frame accumulate or overwrite as above; only the final value is applied.
  - On frame_start with pending=1: pattern_sel <= pending_sel and pending <= 0.
  - A request edge in the same clk as frame_start is queued for the following boundary.
- Update timing: the new pattern_sel and the pattern_changed pulse both appear on the clk after frame_start=1.
- pattern_changed is asserted only if the new value differs from the old value.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Reset and first sync: drive rst mid-frame, release, then sweep hcount/vcount through (0,0), held 2 clks.
  - frame_start=1 for exactly 1 clk; pattern_sel=0; FSM leaves WAIT_SYNC; frame_cnt=1.
- Auto dwell (DWELL_FRAMES=3, NUM_PATTERNS=5, auto_en=1): run 16 frames.
  - pattern_sel sequence per frame is 0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,0.
  - pattern_changed pulses 5 times.
- Manual step: auto_en=0, 3 step rising edges within one frame from pattern_sel=1.
  - pending=1; pattern_sel stays 1 until the boundary, then becomes 4 with one pattern_changed pulse.
  - A 4th step in a later frame gives pattern_sel=0 (wrap).
- Load priority and clamp: step and load rise in the same clk with manual_sel=2.
  - Next boundary gives pattern_sel=2.
  - Then load with manual_sel=7 gives pattern_sel=0 at the next boundary.
- Boundary collision and mode switch: step edge in the same clk as frame_start.
  - Applied one frame later, not at this boundary.
  - Set auto_en=1 while pending=1: pending clears, pattern_sel unchanged, dwell restarts at 0.
- Mid-operation reset: assert rst in RUN_AUTO with pattern_sel=3 and dwell counter=2.
  - All outputs 0 immediately, without waiting for clk edge; frame_cnt=0.

Source files
------------

// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous pattern-select sequencer for the colour-bar generator.
// Latency: frame_start 1 clk after the raster reaches (0,0); pattern_sel/pattern_changed 1 clk after frame_start.
// Backpressure: none; manual requests are queued in a single pending slot and applied at the next boundary.
module vga_pattern_scheduler #(
  parameter int NUM_PATTERNS = 5,
  parameter int DWELL_FRAMES = 60,
  parameter int H_W          = 11,
  parameter int V_W          = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [H_W-1:0] hcount,
  input  logic [V_W-1:0] vcount,
  input  logic           auto_en,
  input  logic           step,
  input  logic           load,
  input  logic [2:0]     manual_sel,
  output logic [2:0]     pattern_sel,
  output logic           frame_start,
  output logic           pattern_changed,
  output logic           pending,
  output logic           auto_mode,
  output logic [15:0]    frame_cnt
);

  typedef enum logic [1:0] {
    WAIT_SYNC  = 2'd0,
    RUN_MANUAL = 2'd1,
    RUN_AUTO   = 2'd2
  } state_t;

  localparam logic [2:0]  LAST_PAT   = 3'(NUM_PATTERNS - 1);
  localparam logic [15:0] LAST_DWELL = 16'(DWELL_FRAMES - 1);

  state_t      state_q, state_d;
  logic [2:0]  pattern_q, pattern_d;
  logic [2:0]  pend_sel_q, pend_sel_d;
  logic        pending_q, pending_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] frame_cnt_q;
  logic        at_origin_q;
  logic        frame_start_q;
  logic        changed_q;
  logic        auto_mode_q;
  logic        step_q;
  logic        load_q;

  logic        at_origin;
  logic        step_edge;
  logic        load_edge;
  logic [2:0]  step_base;

  // Advance one pattern, wrapping the last valid pattern back to 0.
  function automatic logic [2:0] next_pat(input logic [2:0] p);
    return (p >= LAST_PAT) ? 3'd0 : p + 3'd1;
  endfunction

  assign at_origin = (hcount == '0) && (vcount == '0);
  assign step_edge = step & ~step_q;
  assign load_edge = load & ~load_q;

  // Next-state: mode tracking, auto dwell counting and manual request queueing.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    pend_sel_d = pend_sel_q;
    pending_d  = pending_q;
    dwell_d    = dwell_q;
    // A step stacks on top of whatever is queued; if the queue is being
    // applied this same clk the result is identical, so the request lands
    // on the following boundary.
    step_base  = pending_q ? pend_sel_q : pattern_q;
    case (state_q)
      WAIT_SYNC: begin
        pattern_d = 3'd0;
        dwell_d   = 16'd0;
        if (frame_start_q) begin
          state_d = auto_en ? RUN_AUTO : RUN_MANUAL;
        end
      end
      RUN_AUTO: begin
        if (!auto_en) begin
          state_d   = RUN_MANUAL;
          dwell_d   = 16'd0;
          pending_d = 1'b0;
        end else if (frame_start_q) begin
          if (dwell_q == LAST_DWELL) begin
            dwell_d   = 16'd0;
            pattern_d = next_pat(pattern_q);
          end else begin
            dwell_d = dwell_q + 16'd1;
          end
        end
      end
      RUN_MANUAL: begin
        if (auto_en) begin
          state_d   = RUN_AUTO;
          dwell_d   = 16'd0;
          pending_d = 1'b0;
        end else begin
          if (frame_start_q && pending_q) begin
            pattern_d = pend_sel_q;
            pending_d = 1'b0;
          end
          if (load_edge) begin
            pend_sel_d = (manual_sel > LAST_PAT) ? 3'd0 : manual_sel;
            pending_d  = 1'b1;
          end else if (step_edge) begin
            pend_sel_d = next_pat(step_base);
            pending_d  = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_SYNC;
      pattern_q     <= 3'd0;
      pend_sel_q    <= 3'd0;
      pending_q     <= 1'b0;
      dwell_q       <= 16'd0;
      frame_cnt_q   <= 16'd0;
      at_origin_q   <= 1'b0;
      frame_start_q <= 1'b0;
      changed_q     <= 1'b0;
      auto_mode_q   <= 1'b0;
      step_q        <= 1'b0;
      load_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      pend_sel_q    <= pend_sel_d;
      pending_q     <= pending_d;
      dwell_q       <= dwell_d;
      at_origin_q   <= at_origin;
      // The raster parks on (0,0) for two clks; only the rising edge counts.
      frame_start_q <= at_origin & ~at_origin_q;
      changed_q     <= (pattern_d != pattern_q);
      auto_mode_q   <= (state_d == RUN_AUTO);
      step_q        <= step;
      load_q        <= load;
      if (frame_start_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign pattern_sel     = pattern_q;
  assign frame_start     = frame_start_q;
  assign pattern_changed = changed_q;
  assign pending         = pending_q;
  assign auto_mode       = auto_mode_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Bench for vga_pattern_scheduler: directed frames, per-boundary scoreboard.
// Each frame pushes the expected before/after state; a monitor pops on frame_start.
// Reset behaviour is checked directly by the stimulus process.
module tb_vga_pattern_scheduler;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        auto_en;
  logic        step;
  logic        load;
  logic [2:0]  manual_sel;
  logic [2:0]  pattern_sel;
  logic        frame_start;
  logic        pattern_changed;
  logic        pending;
  logic        auto_mode;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  pre_pat;
    logic        pre_pend;
    logic [2:0]  post_pat;
    logic        post_chg;
    logic        post_pend;
    logic        post_auto;
    logic [15:0] cnt;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] exp_cnt = 16'd0;

  vga_pattern_scheduler #(
    .NUM_PATTERNS(5),
    .DWELL_FRAMES(3),
    .H_W(11),
    .V_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hcount(hcount),
    .vcount(vcount),
    .auto_en(auto_en),
    .step(step),
    .load(load),
    .manual_sel(manual_sel),
    .pattern_sel(pattern_sel),
    .frame_start(frame_start),
    .pattern_changed(pattern_changed),
    .pending(pending),
    .auto_mode(auto_mode),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the expected state just before and just after the next boundary.
  task automatic expf(input logic [2:0] pre_pat, input logic pre_pend,
                      input logic [2:0] post_pat, input logic post_pend,
                      input logic post_auto);
    exp_t e;
    exp_cnt     = exp_cnt + 16'd1;
    e.pre_pat   = pre_pat;
    e.pre_pend  = pre_pend;
    e.post_pat  = post_pat;
    e.post_chg  = (post_pat != pre_pat);
    e.post_pend = post_pend;
    e.post_auto = post_auto;
    e.cnt       = exp_cnt;
    expq.push_back(e);
  endtask

  // One 12-clk frame: (0,0) for two clks then a blanking/active tail.
  // Masks raise step/load for one clk at the given cycle index;
  // aen_at toggles auto_en at that index (-1 = never).
  task automatic frame(input logic [15:0] step_m, input logic [15:0] load_m,
                       input int aen_at);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      hcount = (i < 2) ? 11'd0 : 11'(i);
      vcount = (i < 2) ? 10'd0 : 10'd5;
      step   = step_m[i];
      load   = load_m[i];
      if (i == aen_at) auto_en = ~auto_en;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pattern_sel"}, pattern_sel, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_pattern_changed"}, pattern_changed, 0);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_auto_mode"}, auto_mode, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  // Monitor: on every frame_start pulse, pop and compare pre/post state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && frame_start === 1'b1) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_start: got pulse expected none (t=%0t)", $time);
        end else begin
          e = expq.pop_front();
          chk("pre_pattern_sel", pattern_sel, e.pre_pat);
          chk("pre_pending", pending, e.pre_pend);
          @(negedge clk);
          chk("frame_start_width", frame_start, 0);
          chk("post_pattern_sel", pattern_sel, e.post_pat);
          chk("post_pattern_changed", pattern_changed, e.post_chg);
          chk("post_pending", pending, e.post_pend);
          chk("post_auto_mode", auto_mode, e.post_auto);
          chk("post_frame_cnt", frame_cnt, e.cnt);
        end
      end else if (rst !== 1'b1) begin
        chk("changed_outside_boundary", pattern_changed, 0);
      end
    end
  end

  // Watchdog: the sequence is a fixed number of clks, so this only fires on a hang.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected sequence end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [2:0] seq [16];
    seq = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2,
            3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0};

    rst = 1'b0; hcount = 11'd7; vcount = 10'd3;
    auto_en = 1'b1; step = 1'b0; load = 1'b0; manual_sel = 3'd0;
    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // First sync leaves WAIT_SYNC, then auto dwell of 3 frames over 16 frames.
    expf(3'd0, 1'b0, 3'd0, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    for (int k = 1; k < 16; k++) begin
      expf(seq[k-1], 1'b0, seq[k], 1'b0, 1'b1);
      frame(16'h0, 16'h0, -1);
    end
    expf(3'd0, 1'b0, 3'd0, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd0, 1'b0, 3'd0, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd0, 1'b0, 3'd1, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);

    // Manual: three steps in one frame from 1 give 4, a later step wraps to 0.
    auto_en = 1'b0;
    expf(3'd1, 1'b0, 3'd1, 1'b0, 1'b0); frame(16'h00A8, 16'h0, -1);
    expf(3'd1, 1'b1, 3'd4, 1'b0, 1'b0); frame(16'h0008, 16'h0, -1);
    // Step and load together: load of 2 wins.
    manual_sel = 3'd2;
    expf(3'd4, 1'b1, 3'd0, 1'b0, 1'b0); frame(16'h0010, 16'h0010, -1);
    // Out-of-range load clamps to 0.
    manual_sel = 3'd7;
    expf(3'd0, 1'b1, 3'd2, 1'b0, 1'b0); frame(16'h0, 16'h0010, -1);
    // Step in the frame_start clk is held for the following boundary.
    expf(3'd2, 1'b1, 3'd0, 1'b1, 1'b0); frame(16'h0002, 16'h0, -1);
    // Step queued, then switch to auto: queue dropped, pattern kept.
    expf(3'd0, 1'b1, 3'd1, 1'b0, 1'b0); frame(16'h0008, 16'h0, 6);
    expf(3'd1, 1'b0, 3'd1, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd1, 1'b0, 3'd1, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd1, 1'b0, 3'd2, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd2, 1'b0, 3'd2, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd2, 1'b0, 3'd2, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd2, 1'b0, 3'd3, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd3, 1'b0, 3'd3, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);
    expf(3'd3, 1'b0, 3'd3, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);

    // Pattern 3 with dwell at 2: asynchronous reset mid-frame.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 16'd0;
    @(posedge clk);
    expf(3'd0, 1'b0, 3'd0, 1'b0, 1'b1); frame(16'h0, 16'h0, -1);

    repeat (3) @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
